geo_cmd_pipe: RTL and testbench
===============================

# geo_cmd_pipe

Parametrised, stall-aware command pipeline for the geometry processor data path, placed between geometry sub-blocks (plotter → address generator, address generator → pixel writer). It replaces fixed pairs of registers frozen as a whole on downstream busy with DEPTH independent elastic stages. Each stage carries its own valid bit, so bubbles collapse while the output is stalled. It adds a synchronous flush and an occupancy report for the geometry status path.

## Interface
Parameters:
- WIDTH, 40, command payload width in bits (36 for draw commands, 40 for pixel commands).
- DEPTH, 2, number of register stages; legal range 1..8.
- CNT_W, 4, width of occupancy output; must hold DEPTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_rdy  in  1  upstream command valid.
- in_data  in  WIDTH  upstream command payload.
- in_busy  out  1  upstream must hold in_rdy/in_data this cycle.
- out_rdy  out  1  output stage holds a valid command.
- out_data  out  WIDTH  output stage payload.
- out_busy  in  1  downstream cannot accept this cycle (pixel writer draw_busy).
- flush  in  1  synchronous discard of all held commands.
- occupancy  out  CNT_W  number of valid stages (0..DEPTH).
- empty  out  1  high when occupancy == 0.

## Operation
- Stage 0 is the input stage. Stage DEPTH-1 is the output stage. Each stage k has valid v[k] and data d[k].
- Output transfer occurs when v[DEPTH-1] && !out_busy.
- adv[DEPTH-1] = !out_busy. For k < DEPTH-1: adv[k] = !v[k+1] || adv[k+1]. The adv chain is combinational.
- Stage k loads from stage k-1 (or from the input for k=0) when adv[k]:
  - v[k] <= v[k-1] (in_rdy for k=0).
  - d[k] <= d[k-1] only when the source is valid. Data of an invalid stage is don't-care but must not change out_data while out_rdy is low.
- When !adv[k], stage k holds.
- Input accepted when in_rdy && !in_busy. in_busy = reset || flush || (v[0] && !adv[0]).
- A bubble (v[k]=0) under a stalled output is filled on the next cycle. Upstream stages keep advancing until every stage below the stall is full.
- flush: all v[k] <= 0 next cycle. The input is not accepted in a flush cycle (in_busy=1). An output transfer in the same cycle still counts as completed downstream. d[k] are unchanged.
- occupancy is the population count of v[], computed combinationally from registered state. empty = (occupancy == 0).
- No command is ever duplicated, dropped (except by flush/reset) or reordered.

## Timing
- Reset values: all v[k]=0, d[k]=0. Outputs: out_rdy=0, out_data=0, occupancy=0, empty=1, in_busy=1 while reset is high.
- Latency with out_busy low throughout: a command accepted at edge N appears on out_rdy/out_data after edge N+DEPTH-1. That is DEPTH cycles from in_rdy sampled to out_rdy visible.
- Throughput: one command per clock when out_busy is low.
- Stall: when out_busy is high and all stages are valid, in_busy is high in the same cycle (combinational from out_busy).
- Release: the cycle after out_busy falls, the pipe resumes with no extra bubble.
- Simultaneous flush and reset: reset dominates; the result is identical.
- Reset mid-stream: all held commands are discarded. No out_rdy is issued for them.
- DEPTH=1 degenerates to a single register: in_busy = v[0] && out_busy.

## Test plan
- Streaming: DEPTH=2, out_busy=0, in_data=0x01..0x10 on consecutive cycles. Required: out_data 0x01..0x10 on consecutive cycles starting 2 cycles after the first input, in_busy never high, occupancy steady at 2.
- Bubble collapse: DEPTH=3, inputs 0xA at cycle 0 and 0xB at cycle 2, out_busy high from cycle 1. Required: occupancy reaches 2 with v = {1,1,0}, then 0xC is accepted and occupancy=3 with in_busy=1. After out_busy drops, output order is A, B, C.
- Stall/release: full pipe and out_busy held high for 10 cycles. Required: out_data stable, in_busy=1 for all 10 cycles. Then exactly one transfer per cycle after release with no lost data.
- Flush: occupancy=3 (DEPTH=3) and flush pulsed for one cycle with in_rdy=1. Required: in_busy=1 in the flush cycle, occupancy=0 and empty=1 next cycle, and the input presented in the flush cycle is not accepted.
- Reset mid-operation: reset high for 1 cycle while occupancy=2. Required: out_rdy=0, out_data=0, occupancy=0 next cycle, and no stale command is emitted afterwards.
- Parameter sweep: WIDTH=36/40, DEPTH=1..8, random in_rdy/out_busy, 10k cycles with a scoreboard. Required: output sequence equals accepted input sequence and occupancy never exceeds DEPTH.

Source files
------------

// File: rtl/geo_cmd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : geo_cmd_pipe
// Description : Stall-aware elastic command pipeline for the geometry data
//               path. DEPTH independent register stages, each with its own
//               valid bit. Bubbles collapse while the output is stalled.
//               Provides a synchronous flush and an occupancy count.
// Ports       : clk        - system clock (rising edge)
//               reset      - synchronous active-high reset
//               in_rdy     - upstream command valid
//               in_data    - upstream command payload
//               in_busy    - upstream must hold in_rdy/in_data this cycle
//               out_rdy    - output stage holds a valid command
//               out_data   - output stage payload
//               out_busy   - downstream cannot accept this cycle
//               flush      - discard all held commands
//               occupancy  - number of valid stages (0..DEPTH)
//               empty      - no valid stage
// Revision    : 1.0 - initial release
// ============================================================================
module geo_cmd_pipe #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_busy,
    output logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_busy,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];

    logic [DEPTH-1:0] w_adv;     // stage content may move down this cycle
    logic [DEPTH-1:0] w_en;      // stage loads from its source this cycle
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [CNT_W-1:0] w_occ;

    // adv[k] is true when out_busy is low or any stage below k is empty.
    // Evaluated as a running "everything below is full" term rather than a
    // self-referencing vector, which keeps the chain free of comb loops.
    always_comb begin
        logic w_below_full;
        w_adv        = '0;
        w_below_full = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k]     = !out_busy || !w_below_full;
            w_below_full = w_below_full && r_v[k];
        end
    end

    // An empty stage always loads, so bubbles fill even under a stall.
    assign w_en = w_adv | ~r_v;

    always_comb begin
        w_src_v    = '0;
        w_src_v[0] = in_rdy;
        w_src_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_d[k] = r_d[k-1];
        end
    end

    // Equivalent to v[0] && !adv[0], plus reset/flush blocking.
    assign in_busy = reset || flush || !w_en[0];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (reset) begin
                r_v[k] <= 1'b0;
                r_d[k] <= '0;
            end else if (flush) begin
                r_v[k] <= 1'b0;
            end else if (w_en[k]) begin
                r_v[k] <= w_src_v[k];
                // Payload only follows a valid source so out_data stays put
                // while the output stage is empty.
                if (w_src_v[k]) begin
                    r_d[k] <= w_src_d[k];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + CNT_W'(r_v[k]);
        end
    end

    assign out_rdy   = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = w_occ;
    assign empty     = (w_occ == '0);

endmodule
`default_nettype wire

// File: tb/tb_geo_cmd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_geo_cmd_pipe
// Description : Self-checking bench for geo_cmd_pipe (DEPTH=3, WIDTH=40).
//               Table of per-cycle vectors plus hand-written reset sequences
//               and a randomised scoreboard run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_geo_cmd_pipe;

    localparam int C_WIDTH = 40;
    localparam int C_DEPTH = 3;
    localparam int C_CNT_W = 4;

    logic               clk;
    logic               reset;
    logic               in_rdy;
    logic [C_WIDTH-1:0] in_data;
    logic               in_busy;
    logic               out_rdy;
    logic [C_WIDTH-1:0] out_data;
    logic               out_busy;
    logic               flush;
    logic [C_CNT_W-1:0] occupancy;
    logic               empty;

    int checks = 0;
    int errors = 0;

    geo_cmd_pipe #(
        .WIDTH (C_WIDTH),
        .DEPTH (C_DEPTH),
        .CNT_W (C_CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_busy   (in_busy),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_busy  (out_busy),
        .flush     (flush),
        .occupancy (occupancy),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic               in_rdy;
        logic [C_WIDTH-1:0] in_data;
        logic               out_busy;
        logic               flush;
        logic               e_in_busy;
        logic               e_out_rdy;
        logic [C_WIDTH-1:0] e_out_data;
        int                 e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [C_WIDTH-1:0] id, input logic ob,
                       input logic fl, input logic eb, input logic er,
                       input logic [C_WIDTH-1:0] ed, input int eo);
        vec_t v;
        v.in_rdy = ir; v.in_data = id; v.out_busy = ob; v.flush = fl;
        v.e_in_busy = eb; v.e_out_rdy = er; v.e_out_data = ed; v.e_occ = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic ir, input logic [C_WIDTH-1:0] id,
                         input logic ob, input logic fl);
        in_rdy = ir; in_data = id; out_busy = ob; flush = fl;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // i.e. well away from the rising edge.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].in_rdy, tbl[i].in_data, tbl[i].out_busy, tbl[i].flush);
            #1;
            check($sformatf("row%0d in_busy", i), 64'(in_busy), 64'(tbl[i].e_in_busy));
            check($sformatf("row%0d out_rdy", i), 64'(out_rdy), 64'(tbl[i].e_out_rdy));
            check($sformatf("row%0d occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
            check($sformatf("row%0d empty", i), 64'(empty), 64'(tbl[i].e_occ == 0));
            if (tbl[i].e_out_rdy) begin
                check($sformatf("row%0d out_data", i), 64'(out_data), 64'(tbl[i].e_out_data));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_rdy"}, 64'(out_rdy), 64'(0));
        check({tag, " out_data"}, 64'(out_data), 64'(0));
        check({tag, " occupancy"}, 64'(occupancy), 64'(0));
        check({tag, " empty"}, 64'(empty), 64'(1));
    endtask

    // Load two commands under a stall, then reset (optionally with flush).
    task automatic reset_mid_stream(input string tag, input logic with_flush);
        @(negedge clk); drive(1'b1, 40'h31, 1'b1, 1'b0);
        @(negedge clk); drive(1'b1, 40'h32, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check({tag, " pre occupancy"}, 64'(occupancy), 64'(2));
        reset = 1'b1; flush = with_flush;
        #1;
        check({tag, " in_busy in reset"}, 64'(in_busy), 64'(1));
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; out_busy = 1'b0;
        #1;
        check_reset_state(tag);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check($sformatf("%s no stale out_rdy %0d", tag, i), 64'(out_rdy), 64'(0));
        end
    endtask

    logic [C_WIDTH-1:0] sb[$];
    logic [C_WIDTH-1:0] exp_d;
    int                 n_acc;

    // One scoreboard step: checks occupancy/in_busy against the queue model,
    // then records acceptance and verifies any completed transfer.
    task automatic sb_step(input string tag);
        #1;
        check({tag, " occupancy"}, 64'(occupancy), 64'(sb.size()));
        check({tag, " in_busy"}, 64'(in_busy), 64'(sb.size() == C_DEPTH && out_busy));
        if (out_rdy && !out_busy) begin
            if (sb.size() == 0) begin
                check({tag, " unexpected output"}, 64'(out_data), 64'hDEAD);
            end else begin
                exp_d = sb.pop_front();
                check({tag, " out_data"}, 64'(out_data), 64'(exp_d));
            end
        end
        if (in_rdy && !in_busy) sb.push_back(in_data);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        check("reset in_busy", 64'(in_busy), 64'(1));
        @(negedge clk);
        reset = 1'b0;

        // Streaming 0x01..0x10, no stall: output 3 cycles after input.
        for (int c = 0; c < 20; c++) begin
            int ent, emt, occ;
            ent = (c < 16) ? c : 16;
            emt = ((c < 19) ? c : 19) - 3;
            if (emt < 0) emt = 0;
            occ = ent - emt;
            add(c < 16, (c < 16) ? C_WIDTH'(c + 1) : '0, 1'b0, 1'b0,
                1'b0, (c >= 3 && c <= 18), C_WIDTH'(c - 2), occ);
        end

        // Bubble collapse, then 10-cycle full stall, then release.
        add(1, 40'hA, 0, 0, 0, 0, 0,     0);
        add(0, 0,     1, 0, 0, 0, 0,     1);
        add(1, 40'hB, 1, 0, 0, 0, 0,     1);
        add(0, 0,     1, 0, 0, 1, 40'hA, 2);
        add(1, 40'hC, 1, 0, 0, 1, 40'hA, 2);
        for (int i = 0; i < 10; i++) add(1, 40'hD, 1, 0, 1, 1, 40'hA, 3);
        add(1, 40'hD, 0, 0, 0, 1, 40'hA, 3);
        add(1, 40'hE, 0, 0, 0, 1, 40'hB, 3);
        add(0, 0,     0, 0, 0, 1, 40'hC, 3);
        add(0, 0,     0, 0, 0, 1, 40'hD, 2);
        add(0, 0,     0, 0, 0, 1, 40'hE, 1);
        add(0, 0,     0, 0, 0, 0, 0,     0);

        // Flush with a full pipe; 0x24 in the flush cycle must be dropped.
        add(1, 40'h21, 1, 0, 0, 0, 0,      0);
        add(1, 40'h22, 1, 0, 0, 0, 0,      1);
        add(1, 40'h23, 1, 0, 0, 0, 0,      2);
        add(1, 40'h24, 1, 1, 1, 1, 40'h21, 3);
        add(1, 40'h25, 0, 0, 0, 0, 0,      0);
        add(0, 0,      0, 0, 0, 0, 0,      1);
        add(0, 0,      0, 0, 0, 0, 0,      1);
        add(0, 0,      0, 0, 0, 1, 40'h25, 1);
        add(0, 0,      0, 0, 0, 0, 0,      0);

        run_table();

        reset_mid_stream("rst", 1'b0);
        reset_mid_stream("rst+flush", 1'b1);

        // Random traffic against a queue model.
        n_acc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), {32'($urandom), 8'(i)},
                  ($urandom_range(0, 2) == 0), 1'b0);
            if (in_rdy) n_acc++;
            sb_step("rand");
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b0, '0, 1'b0, 1'b0);
            sb_step("drain");
        end
        check("drain queue empty", 64'(sb.size()), 64'(0));
        check("drain empty flag", 64'(empty), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
